// File: rtl/vregs_pkg.sv
// Shared vector register file constants and types.
package vregs_pkg;

    localparam int unsigned NREGS      = 16;
    localparam int unsigned VLEN_BITS  = 256;
    localparam int unsigned VELEM_BITS = 16;

    typedef logic [3:0]           vreg_addr_t;
    typedef logic [VLEN_BITS-1:0] vreg_data_t;

endpackage

// File: rtl/vreg_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant that searches from a rotating pointer.
// The grant is suppressed while rst_n is low.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_any
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    int unsigned     idx;

    // First requester at or after the pointer wins; pointer moves past the winner.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        ptr_d   = ptr_q;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (rst_n && !gnt_any && req[idx[PtrW-1:0]]) begin
                gnt[idx[PtrW-1:0]] = 1'b1;
                gnt_any            = 1'b1;
                if (idx == N - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = PtrW'(idx + 1);
                end
            end
        end
    end

    // Pointer register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vreg_wr_arbiter.sv
// Vector register file write-port arbiter with busy scoreboard.
// Optional performance counters enabled by defining VREG_WR_ARB_PERF_EN.
module vreg_wr_arbiter
    import vregs_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned NREGS     = vregs_pkg::NREGS,
    parameter int unsigned VLEN_BITS = vregs_pkg::VLEN_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*4-1:0]         req_addr,
    input  logic [NREQ*VLEN_BITS-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wEn,
    output vreg_addr_t                wAddr,
    output logic [VLEN_BITS-1:0]      wData,
    input  logic                      iss_valid,
    input  vreg_addr_t                iss_addr,
    output logic                      iss_ok,
    input  vreg_addr_t                rd_addr0,
    input  vreg_addr_t                rd_addr1,
    output logic                      rd_busy0,
    output logic                      rd_busy1,
    output logic [NREGS-1:0]          busy_vec
`ifdef VREG_WR_ARB_PERF_EN
    ,
    output logic [31:0]               perf_grants,
    output logic [31:0]               perf_stalls,
    output logic [31:0]               perf_waw
`endif
);

    logic [NREQ-1:0]      gnt;
    logic                 gnt_any;
    vreg_addr_t           sel_addr;
    logic [VLEN_BITS-1:0] sel_data;
    logic [NREGS-1:0]     busy_q, busy_d;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | req_addr[4*i +: 4];
                sel_data = sel_data | req_data[VLEN_BITS*i +: VLEN_BITS];
            end
        end
    end

    assign iss_ok   = iss_valid & ~busy_q[iss_addr];
    assign rd_busy0 = busy_q[rd_addr0];
    assign rd_busy1 = busy_q[rd_addr1];
    assign busy_vec = busy_q;

    // Scoreboard next state: grant clears, accepted issue sets (set applied last so it wins).
    always_comb begin
        busy_d = busy_q;
        if (gnt_any) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered write port; address and data hold when no grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wEn   <= 1'b0;
            wAddr <= '0;
            wData <= '0;
        end else if (gnt_any) begin
            wEn   <= 1'b1;
            wAddr <= sel_addr;
            wData <= sel_data;
        end else begin
            wEn   <= 1'b0;
        end
    end

`ifdef VREG_WR_ARB_PERF_EN
    logic stall_evt;
    logic waw_evt;

    assign stall_evt = ($countones(req_valid) > 1);
    assign waw_evt   = iss_valid & ~iss_ok;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_grants <= '0;
            perf_stalls <= '0;
            perf_waw    <= '0;
        end else begin
            if (gnt_any && perf_grants != '1) begin
                perf_grants <= perf_grants + 32'd1;
            end
            if (stall_evt && perf_stalls != '1) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
            if (waw_evt && perf_waw != '1) begin
                perf_waw <= perf_waw + 32'd1;
            end
        end
    end
`endif

endmodule
